// File: rtl/data_mem_bank.sv
// Byte-wide big-endian data memory with a single outstanding request and READ_LAT read latency.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses instead of force-aligning them.
module data_mem_bank #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [1:0] CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] eff, base, a1, a2, a3;
  logic          misalign, acc_err, accept;
  logic [31:0]   rd_val, rdata_q;
  logic          err_q;
  logic          unused_addr;

  assign eff         = req_addr[AW-1:0];
  assign unused_addr = ^req_addr[31:AW];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((req_size == 2'b01) && eff[0]) ||
                    ((req_size == 2'b10) && (eff[1:0] != 2'b00));
  assign base     = eff;
`else
  assign misalign = 1'b0;
  always_comb begin
    base = eff;
    case (req_size)
      2'b01:   base = {eff[AW-1:1], 1'b0};
      2'b10:   base = {eff[AW-1:2], 2'b00};
      default: base = eff;
    endcase
  end
`endif

  // Aligned accesses never cross the top of memory, so plain AW-bit increments suffice.
  assign a1      = base + AW'(1);
  assign a2      = base + AW'(2);
  assign a3      = base + AW'(3);
  assign acc_err = (req_size == 2'b11) || misalign;
  assign accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset && accept && req_write && !acc_err) begin
      case (req_size)
        2'b00: mem[base] <= req_wdata[7:0];
        2'b01: begin
          mem[base] <= req_wdata[15:8];
          mem[a1]   <= req_wdata[7:0];
        end
        2'b10: begin
          mem[base] <= req_wdata[31:24];
          mem[a1]   <= req_wdata[23:16];
          mem[a2]   <= req_wdata[15:8];
          mem[a3]   <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (req_size)
      2'b00:   rd_val = {{24{req_signed & mem[base][7]}}, mem[base]};
      2'b01:   rd_val = {{16{req_signed & mem[base][7]}}, mem[base], mem[a1]};
      2'b10:   rd_val = {mem[base], mem[a1], mem[a2], mem[a3]};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (req_write || acc_err) ? '0 : rd_val;
      err_q   <= acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_write || (READ_LAT == 1)) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 2'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Scoreboard bench for data_mem_bank: random accesses checked against a byte-array reference model.
module tb_data_mem_bank;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_bank #(.DEPTH_BYTES(DEPTH), .READ_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];

  logic [7:0] mem_m [DEPTH];
  int  busy_until = -1;
  bit  checks_on = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference: byte array addressed modulo DEPTH, big-endian composition with arithmetic.
  function automatic void model_access(input bit w, input logic [1:0] sz, input bit sg,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] data, output logic err);
    int n, base;
    longint unsigned v;
    data = '0;
    err  = 1'b0;
    if (sz == 2'b11) begin err = 1'b1; return; end
    n    = 1 << sz;
    base = int'(a % DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (base % n != 0) begin err = 1'b1; return; end
`else
    base = base - base % n;
`endif
    if (w) begin
      for (int i = 0; i < n; i++) mem_m[base + i] = 8'(d >> (8 * (n - 1 - i)));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + mem_m[base + i];
      if (sg && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      data = 32'(v);
    end
  endfunction

  // One cycle of stimulus, entered and left at a falling edge.
  task automatic step(input bit v, input bit w, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] d, input bit rst_n,
                      input bit ovr, input logic [31:0] ovr_data);
    bit rdy_m;
    exp_t e;
    rdy_m = (cyc > busy_until);
    if (checks_on) begin
      n_cmp++;
      if (req_ready !== rdy_m) begin
        n_bad++;
        $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, rdy_m);
      end
    end
    reset = rst_n; req_valid = v; req_write = w; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = d;
    if (!rst_n) begin
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      busy_until = cyc;
    end else if (v && rdy_m) begin
      model_access(w, sz, sg, a, d, e.data, e.err);
      if (ovr) e.data = ovr_data;
      e.cyc = cyc + ((w) ? 1 : int'(LAT));
      sb.push_back(e);
      busy_until = e.cyc;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] d, input bit ovr, input logic [31:0] ovr_data);
    while (cyc <= busy_until) idle();
    step(1'b1, w, sz, sg, a, d, 1'b1, ovr, ovr_data);
  endtask

  always @(negedge clk) begin
    if (checks_on) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_rsp cyc=%0d expected_at=%0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_rsp cyc=%0d data=%h err=%b", cyc, rsp_rdata, rsp_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_cmp++;
          if (e.cyc != cyc) begin
            n_bad++;
            $display("FAIL rsp_timing got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
          end
          n_cmp++;
          if (rsp_rdata !== e.data || rsp_err !== e.err) begin
            n_bad++;
            $display("FAIL rsp_data cyc=%0d got=%h/%b exp=%h/%b", cyc, rsp_rdata, rsp_err, e.data, e.err);
          end
        end
      end else begin
        n_cmp++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_zero cyc=%0d got=%h/%b exp=00000000/0", cyc, rsp_rdata, rsp_err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    @(negedge clk);
    repeat (4) step(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    checks_on = 1'b1;

    for (int unsigned a = 0; a < DEPTH; a += 4) issue(1'b1, 2'b10, 1'b0, a, $urandom, 1'b0, '0);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, '0);
    issue(1'b0, 2'b00, 1'b0, 32'h11, '0, 1'b1, 32'h00000022);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h80, 1'b0, '0);
    issue(1'b0, 2'b00, 1'b1, 32'h12, '0, 1'b1, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h12, '0, 1'b1, 32'h00000080);
    issue(1'b0, 2'b01, 1'b1, 32'h12, '0, 1'b1, 32'hFFFF8044);
    issue(1'b1, 2'b10, 1'b0, 32'h13, 32'hDEADBEEF, 1'b0, '0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, '0, 1'b0, '0);
    issue(1'b0, 2'b11, 1'b0, 32'h20, '0, 1'b0, '0);
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b0, '0);
    issue(1'b0, 2'b10, 1'b0, 32'h120, '0, 1'b0, '0);

    // Reset one cycle into a read: the response is dropped, memory survives.
    issue(1'b0, 2'b10, 1'b0, 32'h40, '0, 1'b0, '0);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, '0, 1'b0, 1'b0, '0);
    idle();
    issue(1'b0, 2'b10, 1'b0, 32'h40, '0, 1'b0, '0);
    // Write presented while reset is low must not land.
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h50, 32'hA5A5A5A5, 1'b0, 1'b0, '0);
    issue(1'b0, 2'b10, 1'b0, 32'h50, '0, 1'b0, '0);

    for (int i = 0; i < 600; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step($urandom_range(0, 99) < 65, $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
           $urandom, $urandom, $urandom_range(0, 59) != 0, 1'b0, '0);
    end

    for (int i = 0; i < 12 && sb.size() > 0; i++) idle();
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_bank.md
DATA_MEM_BANK -- requirements
Module: data_mem_bank

Interface
REQ-001 Parameter DEPTH_BYTES, default 256, SHALL set memory size in bytes (power of two, 16..65536).
REQ-002 Parameter READ_LAT, default 1, SHALL set read latency in cycles (1..4).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be reset, synchronous and active-low.
REQ-005 req_valid  input  1  SHALL flag a request present.
REQ-006 req_ready  output  1  SHALL flag the block can accept a request this cycle.
REQ-007 req_write  input  1  SHALL select write (1) or read (0).
REQ-008 req_size  input  2  SHALL select access size: 00 byte, 01 halfword, 10 word; 11 reserved.
REQ-009 req_signed  input  1  SHALL select sign extension for byte/halfword reads.
REQ-010 req_addr  input  32  SHALL carry the byte address.
REQ-011 req_wdata  input  32  SHALL carry write data, right-justified for byte/halfword.
REQ-012 rsp_valid  output  1  SHALL pulse one cycle per accepted request.
REQ-013 rsp_rdata  output  32  SHALL carry read data, valid only with rsp_valid.
REQ-014 rsp_err  output  1  SHALL flag a rejected access, valid only with rsp_valid.

Function
REQ-015 Storage SHALL be byte-wide, big-endian: word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
REQ-016 Effective address SHALL be req_addr modulo DEPTH_BYTES; multi-byte accesses never straddle wrap once aligned.
REQ-017 Request accepted in cycle T iff req_valid and req_ready; all req_* sampled only at T.
REQ-018 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-019 IDLE->RESP on accepted write or on read with READ_LAT = 1; IDLE->WAIT on read with READ_LAT > 1.
REQ-020 WAIT SHALL count down and enter RESP so rsp_valid is high exactly in cycle T+READ_LAT.
REQ-021 Write SHALL update only the addressed bytes at the clock edge ending cycle T; rsp_valid at T+1, rsp_rdata = 0.
REQ-022 Read data SHALL be captured at T; byte/halfword zero-extended if req_signed = 0, sign-extended if 1.
REQ-023 RESP SHALL last one cycle and return to IDLE; rsp_valid, rsp_err, rsp_rdata SHALL be 0 outside RESP.
REQ-024 req_size = 11 SHALL set rsp_err = 1, no memory change, rsp_rdata = 0, same latency as a normal access.
REQ-025 req_valid while req_ready = 0 SHALL be ignored (not queued).
REQ-026 Back-to-back: new request accepted in the IDLE cycle after RESP; maximum throughput one access per READ_LAT+1 cycles.

Reset
REQ-027 reset = 0 at a rising edge SHALL force IDLE, clear the counter, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0 next cycle.
REQ-028 Reset SHALL NOT clear memory contents; in-flight read is discarded with no rsp_valid.
REQ-029 Write accepted in the same cycle reset = 0 SHALL NOT modify memory.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN defined: halfword with addr[0] = 1 or word with addr[1:0] != 00 SHALL give rsp_err = 1, no memory change, rsp_rdata = 0.
REQ-031 Macro DMEM_ALIGN_CHECK_EN undefined: misaligned addresses SHALL be forced aligned (low bits cleared), rsp_err = 0.

Verification
REQ-032 Word write 0x11223344 @0x10, then byte read @0x11 unsigned -> rsp_rdata = 0x00000022, rsp_err = 0.
REQ-033 Byte write 0x80 @0x12, byte read @0x12 signed -> 0xFFFFFF80; unsigned -> 0x00000080; halfword read @0x12 signed -> 0xFFFF8044 (given REQ-032 data).
REQ-034 READ_LAT = 3, read accepted cycle 5 -> rsp_valid high only in cycle 8; req_ready low cycles 6-8; req_valid in cycle 7 ignored.
REQ-035 With DMEM_ALIGN_CHECK_EN, word write 0xDEADBEEF @0x13 -> rsp_err = 1; subsequent word read @0x10 returns prior contents unchanged.
REQ-036 reset = 0 in cycle T+1 of READ_LAT = 3 read -> no rsp_valid; req_ready = 1 cycle after reset released; memory contents retained.
